fetch_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage MIPS pipeline; it produces the instruction word that the ID-stage decoder consumes.

---
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over req/valid,
// and feeds the IF/ID register (with a one-entry skid buffer) to the decoder.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic [1:0]  id_pcsrc,
  input  logic [31:0] id_jr_target,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  id_opcode,
  output logic [5:0]  id_funct
);

  typedef enum logic {FETCH, DROP} stateT;

  stateT       state, stateNext;
  logic [31:0] pc;
  logic [31:0] reqAddr;
  logic        reqActive;
  logic        skidFull;
  logic [31:0] skidInstr;
  logic [31:0] skidPcPlus4;

  logic        redirect;
  logic [31:0] redirTarget;
  logic [31:0] jumpTarget;
  logic        accept;
  logic        deliver;
  logic [31:0] fetchPlus4;

  assign id_opcode = id_instr[31:26];
  assign id_funct  = id_instr[5:0];

  // Once a request is issued its address comes from reqAddr, so pc may move freely.
  assign imem_req   = reset_n && ((state == DROP) || !skidFull);
  assign imem_addr  = reqActive ? reqAddr : pc;
  assign fetchPlus4 = imem_addr + 32'd4;
  assign accept     = imem_req && imem_valid;
  assign deliver    = accept && (state == FETCH) && !redirect;
  assign jumpTarget = {id_pc_plus4[31:28], id_instr[25:0], 2'b00};

  // EX branches beat ID jumps; ID jumps only count for a real, unstalled instruction.
  always_comb begin
    redirect    = 1'b0;
    redirTarget = pc;
    if (ex_branch_taken) begin
      redirect    = 1'b1;
      redirTarget = ex_branch_target & ~32'd3;
    end else if (id_valid && !stall && (id_pcsrc == 2'b01)) begin
      redirect    = 1'b1;
      redirTarget = jumpTarget;
    end else if (id_valid && !stall && (id_pcsrc == 2'b10)) begin
      redirect    = 1'b1;
      redirTarget = id_jr_target & ~32'd3;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      FETCH: if (redirect && imem_req && !imem_valid) stateNext = DROP;
      DROP:  if (imem_valid) stateNext = FETCH;
      default: stateNext = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      reqAddr     <= RESET_PC;
      reqActive   <= 1'b0;
      skidFull    <= 1'b0;
      skidInstr   <= 32'd0;
      skidPcPlus4 <= 32'd0;
      id_valid    <= 1'b0;
      id_instr    <= 32'd0;
      id_pc_plus4 <= 32'd0;
    end else begin
      state <= stateNext;

      if (imem_req && !imem_valid) begin
        reqActive <= 1'b1;
        reqAddr   <= imem_addr;
      end else if (accept) begin
        reqActive <= 1'b0;
      end

      if (redirect)
        pc <= redirTarget;
      else if (deliver)
        pc <= fetchPlus4;

      // The skid only fills while stalled and always drains before new words reach IF/ID.
      if (redirect) begin
        skidFull    <= 1'b0;
        id_valid    <= 1'b0;
        id_instr    <= 32'd0;
        id_pc_plus4 <= 32'd0;
      end else if (!stall) begin
        if (skidFull) begin
          skidFull    <= 1'b0;
          id_valid    <= 1'b1;
          id_instr    <= skidInstr;
          id_pc_plus4 <= skidPcPlus4;
        end else if (deliver) begin
          id_valid    <= 1'b1;
          id_instr    <= imem_rdata;
          id_pc_plus4 <= fetchPlus4;
        end else begin
          id_valid    <= 1'b0;
          id_instr    <= 32'd0;
          id_pc_plus4 <= 32'd0;
        end
      end else if (deliver) begin
        skidFull    <= 1'b1;
        skidInstr   <= imem_rdata;
        skidPcPlus4 <= fetchPlus4;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small req/valid memory model returning rdata=addr
// (with one overridable word) and a tb-driven decoder PCSrc.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic [1:0]  id_pcsrc;
  logic [31:0] id_jr_target;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;

  int          checks = 0;
  int          failures = 0;
  int          memLat = 0;
  int          cnt = 0;
  logic [31:0] specAddr = 32'h1;
  logic [31:0] specWord = 32'h0;
  logic        decodeEn = 1'b0;
  logic [1:0]  pcsrcDrv = 2'b00;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .stall(stall), .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .id_pcsrc(id_pcsrc), .id_jr_target(id_jr_target),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
    .id_opcode(id_opcode), .id_funct(id_funct)
  );

  always #5 clk = ~clk;

  // Memory answers after memLat idle request cycles; memLat=0 is zero-wait.
  assign imem_valid = imem_req && (cnt >= memLat);
  assign imem_rdata = (imem_addr == specAddr) ? specWord : imem_addr;
  assign id_pcsrc   = (decodeEn && id_valid && id_opcode == 6'h02) ? 2'b01 : pcsrcDrv;

  always @(posedge clk) begin
    if (!imem_req || imem_valid) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int lat);
    reset_n = 1'b0;
    stall = 1'b0;
    ex_branch_taken = 1'b0;
    ex_branch_target = 32'h0;
    id_jr_target = 32'h0;
    pcsrcDrv = 2'b00;
    decodeEn = 1'b0;
    specAddr = 32'h1;
    memLat = lat;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    stall = 1'b0;
    ex_branch_taken = 1'b0;
    ex_branch_target = 32'h0;
    id_jr_target = 32'h0;
    memLat = 0;
    repeat (2) cyc();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr got=%h exp=0", id_instr); end
    checks++; if (id_pc_plus4 !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc4 got=%h exp=0", id_pc_plus4); end
    cyc();
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL release_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL release_addr got=%h exp=0", imem_addr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expInstr;
    doReset(0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      @(negedge clk);
      checks++;
      if (imem_addr !== 32'(4 * i)) begin failures++; $display("[TB] FAIL seq_addr[%0d] got=%h exp=%h", i, imem_addr, 32'(4 * i)); end
      if (i > 0) begin
        expInstr = 32'(4 * (i - 1));
        checks++;
        if (id_valid !== 1'b1) begin failures++; $display("[TB] FAIL seq_valid[%0d] got=%b exp=1", i, id_valid); end
        checks++;
        if (id_instr !== expInstr) begin failures++; $display("[TB] FAIL seq_instr[%0d] got=%h exp=%h", i, id_instr, expInstr); end
        checks++;
        if (id_pc_plus4 !== 32'(4 * i)) begin failures++; $display("[TB] FAIL seq_pc4[%0d] got=%h exp=%h", i, id_pc_plus4, 32'(4 * i)); end
        checks++;
        if (id_funct !== expInstr[5:0]) begin failures++; $display("[TB] FAIL seq_funct[%0d] got=%h exp=%h", i, id_funct, expInstr[5:0]); end
      end
    end
  endtask

  task automatic test_jump();
    doReset(0);
    specAddr = 32'h8;
    specWord = 32'h0800_0010;
    decodeEn = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    checks++; if (id_instr !== 32'h0800_0010) begin failures++; $display("[TB] FAIL j_instr got=%h exp=08000010", id_instr); end
    checks++; if (id_opcode !== 6'h02) begin failures++; $display("[TB] FAIL j_opcode got=%h exp=02", id_opcode); end
    cyc();
    @(negedge clk);
    checks++; if (imem_addr !== 32'h40) begin failures++; $display("[TB] FAIL j_addr got=%h exp=40", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("[TB] FAIL j_bubble got=%b exp=0", id_valid); end
    cyc();
    @(negedge clk);
    checks++; if (id_instr !== 32'h40) begin failures++; $display("[TB] FAIL j_next_instr got=%h exp=40", id_instr); end
    checks++; if (id_pc_plus4 !== 32'h44) begin failures++; $display("[TB] FAIL j_next_pc4 got=%h exp=44", id_pc_plus4); end
  endtask

  task automatic test_branch_priority();
    doReset(0);
    cyc();
    ex_branch_taken = 1'b1;
    ex_branch_target = 32'h100;
    stall = 1'b1;
    pcsrcDrv = 2'b10;
    id_jr_target = 32'h300;
    @(negedge clk);
    checks++; if (id_valid !== 1'b1) begin failures++; $display("[TB] FAIL br_pre_valid got=%b exp=1", id_valid); end
    cyc();
    ex_branch_taken = 1'b0;
    stall = 1'b0;
    pcsrcDrv = 2'b00;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("[TB] FAIL br_addr got=%h exp=100", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("[TB] FAIL br_flush_valid got=%b exp=0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin failures++; $display("[TB] FAIL br_flush_instr got=%h exp=0", id_instr); end
    cyc();
    @(negedge clk);
    checks++; if (id_instr !== 32'h100) begin failures++; $display("[TB] FAIL br_next_instr got=%h exp=100", id_instr); end
    checks++; if (id_pc_plus4 !== 32'h104) begin failures++; $display("[TB] FAIL br_next_pc4 got=%h exp=104", id_pc_plus4); end
  endtask

  task automatic test_jr();
    doReset(0);
    cyc();
    pcsrcDrv = 2'b10;
    id_jr_target = 32'h80;
    cyc();
    pcsrcDrv = 2'b00;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h80) begin failures++; $display("[TB] FAIL jr_addr got=%h exp=80", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("[TB] FAIL jr_bubble got=%b exp=0", id_valid); end
    cyc();
    pcsrcDrv = 2'b11;
    @(negedge clk);
    checks++; if (id_instr !== 32'h80) begin failures++; $display("[TB] FAIL jr_instr got=%h exp=80", id_instr); end
    cyc();
    pcsrcDrv = 2'b00;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h88) begin failures++; $display("[TB] FAIL pcsrc11_addr got=%h exp=88", imem_addr); end
    checks++; if (id_instr !== 32'h84) begin failures++; $display("[TB] FAIL pcsrc11_instr got=%h exp=84", id_instr); end
  endtask

  task automatic test_drop();
    bit found;
    int k;
    doReset(2);
    k = 0;
    @(negedge clk);
    found = (imem_addr == 32'h10);
    while (!found && k < 60) begin
      cyc();
      @(negedge clk);
      found = (imem_addr == 32'h10);
      k++;
    end
    checks++; if (!found) begin failures++; $display("[TB] FAIL drop_wait_addr10 got=%h exp=10", imem_addr); end
    cyc();
    ex_branch_taken = 1'b1;
    ex_branch_target = 32'h203;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h10) begin failures++; $display("[TB] FAIL drop_hold1 got=%h exp=10", imem_addr); end
    cyc();
    ex_branch_taken = 1'b0;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h10) begin failures++; $display("[TB] FAIL drop_hold2 got=%h exp=10", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL drop_req got=%b exp=1", imem_req); end
    cyc();
    @(negedge clk);
    checks++; if (imem_addr !== 32'h200) begin failures++; $display("[TB] FAIL drop_new_addr got=%h exp=200", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("[TB] FAIL drop_discard got=%b exp=0", id_valid); end
    repeat (3) cyc();
    @(negedge clk);
    checks++; if (id_instr !== 32'h200) begin failures++; $display("[TB] FAIL drop_instr got=%h exp=200", id_instr); end
    checks++; if (id_pc_plus4 !== 32'h204) begin failures++; $display("[TB] FAIL drop_pc4 got=%h exp=204", id_pc_plus4); end
  endtask

  task automatic test_stall_skid();
    doReset(0);
    repeat (2) cyc();
    stall = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL skid_req_first got=%b exp=1", imem_req); end
    cyc();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL skid_req_full got=%b exp=0", imem_req); end
    checks++; if (id_instr !== 32'h4) begin failures++; $display("[TB] FAIL skid_hold got=%h exp=4", id_instr); end
    cyc();
    cyc();
    stall = 1'b0;
    @(negedge clk);
    checks++; if (id_instr !== 32'h4) begin failures++; $display("[TB] FAIL skid_hold_last got=%h exp=4", id_instr); end
    cyc();
    @(negedge clk);
    checks++; if (id_instr !== 32'h8) begin failures++; $display("[TB] FAIL skid_drain got=%h exp=8", id_instr); end
    checks++; if (id_pc_plus4 !== 32'hC) begin failures++; $display("[TB] FAIL skid_drain_pc4 got=%h exp=c", id_pc_plus4); end
    checks++; if (imem_addr !== 32'hC) begin failures++; $display("[TB] FAIL skid_resume_addr got=%h exp=c", imem_addr); end
    cyc();
    @(negedge clk);
    checks++; if (id_instr !== 32'hC) begin failures++; $display("[TB] FAIL skid_after got=%h exp=c", id_instr); end
  endtask

  task automatic test_wrap();
    doReset(0);
    ex_branch_taken = 1'b1;
    ex_branch_target = 32'hFFFF_FFFE;
    cyc();
    ex_branch_taken = 1'b0;
    @(negedge clk);
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
    cyc();
    @(negedge clk);
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL wrap_next_addr got=%h exp=0", imem_addr); end
    checks++; if (id_pc_plus4 !== 32'h0) begin failures++; $display("[TB] FAIL wrap_pc4 got=%h exp=0", id_pc_plus4); end
    checks++; if (id_opcode !== 6'h3F) begin failures++; $display("[TB] FAIL wrap_opcode got=%h exp=3f", id_opcode); end
    checks++; if (id_funct !== 6'h3C) begin failures++; $display("[TB] FAIL wrap_funct got=%h exp=3c", id_funct); end
  endtask

  task automatic test_reset_midfetch();
    doReset(0);
    cyc();
    cyc();
    memLat = 5;
    @(negedge clk);
    checks++; if (id_instr !== 32'h4) begin failures++; $display("[TB] FAIL mid_pre_instr got=%h exp=4", id_instr); end
    cyc();
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL mid_req_in_reset got=%b exp=0", imem_req); end
    cyc();
    reset_n = 1'b1;
    memLat = 0;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL mid_addr got=%h exp=0", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL mid_req got=%b exp=1", imem_req); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_valid got=%b exp=0", id_valid); end
    cyc();
    @(negedge clk);
    checks++; if (id_instr !== 32'h0 || id_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_first instr=%h valid=%b exp=0/1", id_instr, id_valid); end
    checks++; if (id_pc_plus4 !== 32'h4) begin failures++; $display("[TB] FAIL mid_first_pc4 got=%h exp=4", id_pc_plus4); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_jump();
    test_branch_priority();
    test_jr();
    test_drop();
    test_stall_skid();
    test_wrap();
    test_reset_midfetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
